// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus master port.
// State encoding, mode constants and default widths.
package bus_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL0,
    S_SEL1,
    S_WAIT_GRANT,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_DONE,
    S_ABORT
  } state_e;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TIMEOUT    = 255;
  localparam int SEL_WIDTH      = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// Bit counter plus combined PISO/SIPO shift register.
// Serial input lands at bit len_m1 so LSB-first data ends up right-aligned.
module serial_shifter #(
  parameter int W  = 12,
  parameter int OW = 8,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          shift,
  input  logic          sin,
  input  logic [CW-1:0] len_m1,
  output logic          sout,
  output logic [OW-1:0] data,
  output logic          last
);

  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = '0;
    end else if (shift) begin
      data_d         = data_q >> 1;
      data_d[len_m1] = sin;
      cnt_d          = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sout = data_q[0];
  assign data = data_q[OW-1:0];
  assign last = (cnt_q == len_m1);

endmodule

// File: rtl/master_port.sv
// Master-side bus controller: one bus transaction per command.
// Arbiter handshake, serial select, address/data shifting, timeout.
module master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [SEL_WIDTH-1:0]  cmd_slave,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  m_request,
  output logic                  m_slave_sel,
  input  logic                  m_grant,
  input  logic                  arbiter_busy,
  input  logic                  bus_busy,
  output logic                  m_valid,
  output logic                  m_mode,
  output logic                  m_wdata,
  input  logic                  s_rvalid,
  input  logic                  s_rdata,
  output logic                  trans_done
);

  localparam int SW = max_int(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW = $clog2(SW);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic [SEL_WIDTH-1:0]   slave_q, slave_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic                   sh_load, sh_shift;
  logic                   sh_sout, sh_last;
  logic [SW-1:0]          sh_ld_data;
  logic [CW-1:0]          sh_len_m1;
  logic [DATA_WIDTH-1:0]  sh_data;
  logic                   bus_free;

  assign bus_free  = !arbiter_busy && !bus_busy;
  assign sh_len_m1 = (state_q == S_ADDR) ? CW'(ADDR_WIDTH - 1)
                                         : CW'(DATA_WIDTH - 1);

  serial_shifter #(
    .W  (SW),
    .OW (DATA_WIDTH),
    .CW (CW)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data (sh_ld_data),
    .shift     (sh_shift),
    .sin       (s_rdata),
    .len_m1    (sh_len_m1),
    .sout      (sh_sout),
    .data      (sh_data),
    .last      (sh_last)
  );

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    slave_d    = slave_q;
    wdata_d    = wdata_q;
    tmo_d      = tmo_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_ld_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          write_d    = cmd_write;
          slave_d    = cmd_slave;
          wdata_d    = cmd_wdata;
          sh_load    = 1'b1;
          sh_ld_data = SW'(cmd_addr);
          state_d    = S_SEL0;
        end
      end
      S_SEL0: if (bus_free) state_d = S_SEL1;
      S_SEL1: state_d = S_WAIT_GRANT;
      S_WAIT_GRANT: begin
        // busy bus without our grant means the other master won
        if (m_grant)       state_d = S_ADDR;
        else if (bus_busy) state_d = S_SEL0;
      end
      S_ADDR: begin
        if (!m_grant) begin
          state_d = S_ABORT;
        end else begin
          sh_shift = 1'b1;
          if (sh_last) begin
            sh_load = 1'b1;
            tmo_d   = '0;
            if (write_q == MODE_WRITE) begin
              sh_ld_data = SW'(wdata_q);
              state_d    = S_WDATA;
            end else begin
              state_d    = S_RDATA;
            end
          end
        end
      end
      S_WDATA: begin
        if (!m_grant) begin
          state_d = S_ABORT;
        end else begin
          sh_shift = 1'b1;
          if (sh_last) state_d = S_DONE;
        end
      end
      S_RDATA: begin
        if (!m_grant) begin
          state_d = S_ABORT;
        end else if (s_rvalid && sh_last) begin
          sh_shift = 1'b1;
          state_d  = S_DONE;
        end else begin
          sh_shift = s_rvalid;
          if (tmo_q == TW'(TIMEOUT - 1)) state_d = S_ABORT;
          else                           tmo_d   = tmo_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      slave_q <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      slave_q <= slave_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    m_request   = 1'b0;
    m_slave_sel = 1'b0;
    m_valid     = 1'b0;
    m_mode      = 1'b0;
    m_wdata     = 1'b0;
    trans_done  = 1'b0;
    unique case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_SEL0: begin
        m_request   = bus_free;
        m_slave_sel = bus_free & slave_q[0];
      end
      S_SEL1: begin
        m_request   = 1'b1;
        m_slave_sel = slave_q[1];
      end
      S_ADDR, S_WDATA: begin
        m_valid = 1'b1;
        m_mode  = write_q;
        m_wdata = sh_sout;
      end
      S_DONE: begin
        trans_done = 1'b1;
        rsp_valid  = 1'b1;
        rsp_rdata  = (write_q == MODE_WRITE) ? '0 : sh_data;
      end
      S_ABORT: begin
        trans_done = 1'b1;
        rsp_valid  = 1'b1;
        rsp_err    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
